// File: rtl/matrix_feeder.sv
// Operand buffers, skewed A/B streams and result capture for a 4x4
// output-stationary systolic array; one multiply per start pulse.
module matrix_feeder #(
  parameter int DRAIN_CYCLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic        ld_sel,
  input  logic [3:0]  ld_addr,
  input  logic [7:0]  ld_data,
  input  logic        start,
  output logic [7:0]  a1,
  output logic [7:0]  a2,
  output logic [7:0]  a3,
  output logic [7:0]  a4,
  output logic [7:0]  b1,
  output logic [7:0]  b2,
  output logic [7:0]  b3,
  output logic [7:0]  b4,
  output logic        arr_clr,
  input  logic [16:0] c1,
  input  logic [16:0] c2,
  input  logic [16:0] c3,
  input  logic [16:0] c4,
  input  logic [16:0] c5,
  input  logic [16:0] c6,
  input  logic [16:0] c7,
  input  logic [16:0] c8,
  input  logic [16:0] c9,
  input  logic [16:0] c10,
  input  logic [16:0] c11,
  input  logic [16:0] c12,
  input  logic [16:0] c13,
  input  logic [16:0] c14,
  input  logic [16:0] c15,
  input  logic [16:0] c16,
  input  logic [3:0]  rd_addr,
  output logic [16:0] rd_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FEED, DRAIN, CAPTURE, DONE
  } state_t;

  localparam logic [7:0] FEED_LAST  = 8'd6;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  amem [16];
  logic [7:0]  bmem [16];
  logic [16:0] res  [16];
  logic [16:0] c_in [16];
  logic [7:0]  a_q  [4];
  logic [7:0]  b_q  [4];
  logic [7:0]  a_n  [4];
  logic [7:0]  b_n  [4];

  assign c_in[0]  = c1;
  assign c_in[1]  = c2;
  assign c_in[2]  = c3;
  assign c_in[3]  = c4;
  assign c_in[4]  = c5;
  assign c_in[5]  = c6;
  assign c_in[6]  = c7;
  assign c_in[7]  = c8;
  assign c_in[8]  = c9;
  assign c_in[9]  = c10;
  assign c_in[10] = c11;
  assign c_in[11] = c12;
  assign c_in[12] = c13;
  assign c_in[13] = c14;
  assign c_in[14] = c15;
  assign c_in[15] = c16;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = FEED;
        cnt_nxt   = '0;
      end
      FEED: begin
        if (cnt == FEED_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (DRAIN_CYCLES == 0) ? CAPTURE : DRAIN;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) state_nxt = CAPTURE;
        else cnt_nxt = cnt + 8'd1;
      end
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream values are chosen for the upcoming step so they are
  // registered and stable for the whole FEED cycle they belong to.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_n[i] = '0;
      b_n[i] = '0;
    end
    if (state_nxt == FEED) begin
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (int'(cnt_nxt) == i + k) begin
            a_n[i] = amem[4'(i * 4 + k)];
            b_n[i] = bmem[4'(k * 4 + i)];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= a_n[i];
        b_q[i] <= b_n[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) begin
        amem[k] <= '0;
        bmem[k] <= '0;
      end
    end else if (ld_valid && state == IDLE) begin
      if (ld_sel) bmem[ld_addr] <= ld_data;
      else amem[ld_addr] <= ld_data;
    end
  end

  // Array ports are column-major; the buffer is row-major.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 16; k++) res[k] <= '0;
    end else if (state == CAPTURE) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          res[4'(r * 4 + c)] <= c_in[4'(c * 4 + r)];
        end
      end
    end
  end

  assign a1 = a_q[0];
  assign a2 = a_q[1];
  assign a3 = a_q[2];
  assign a4 = a_q[3];
  assign b1 = b_q[0];
  assign b2 = b_q[1];
  assign b3 = b_q[2];
  assign b4 = b_q[3];

  assign arr_clr = (state == CLEAR);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rd_data = res[rd_addr];

endmodule

// File: tb/tb_matrix_feeder.sv
// Bench for matrix_feeder: a behavioural 4x4 systolic array consumes the
// skewed streams and feeds results back; vectors carry expected C values.
module tb_matrix_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, ld_sel, start;
  logic [3:0]  ld_addr, rd_addr;
  logic [7:0]  ld_data;
  logic [7:0]  a1, a2, a3, a4, b1, b2, b3, b4;
  logic        arr_clr, busy, done;
  logic [16:0] rd_data;
  logic [16:0] cw [16];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  matrix_feeder #(.DRAIN_CYCLES(6)) dut (
    .clk(clk), .reset(rst_n),
    .ld_valid(ld_valid), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .b1(b1), .b2(b2), .b3(b3), .b4(b4),
    .arr_clr(arr_clr),
    .c1(cw[0]),   .c2(cw[1]),   .c3(cw[2]),   .c4(cw[3]),
    .c5(cw[4]),   .c6(cw[5]),   .c7(cw[6]),   .c8(cw[7]),
    .c9(cw[8]),   .c10(cw[9]),  .c11(cw[10]), .c12(cw[11]),
    .c13(cw[12]), .c14(cw[13]), .c15(cw[14]), .c16(cw[15]),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done)
  );

  // Output-stationary array: A moves right, B moves down, one hop/cycle.
  logic [7:0]  aw [4];
  logic [7:0]  bw [4];
  logic [7:0]  ha [4][4];
  logic [7:0]  vb [4][4];
  logic [16:0] acc [4][4];

  assign aw[0] = a1;
  assign aw[1] = a2;
  assign aw[2] = a3;
  assign aw[3] = a4;
  assign bw[0] = b1;
  assign bw[1] = b2;
  assign bw[2] = b3;
  assign bw[3] = b4;

  function automatic logic [7:0] ina(int i, int j);
    if (j == 0) return aw[i];
    return ha[i][j-1];
  endfunction

  function automatic logic [7:0] inb(int i, int j);
    if (i == 0) return bw[j];
    return vb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ha[i][j]  <= ina(i, j);
        vb[i][j]  <= inb(i, j);
        acc[i][j] <= arr_clr ? 17'd0
                   : acc[i][j] + 17'(ina(i, j)) * 17'(inb(i, j));
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        cw[c * 4 + r] = acc[r][c];
  end

  typedef struct packed {
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [15:0][16:0] c;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [16:0] mm(vec_t v, int r, int c);
    logic [17:0] s;
    s = '0;
    for (int k = 0; k < 4; k++)
      s = s + 18'(v.a[4'(r * 4 + k)]) * 18'(v.b[4'(k * 4 + c)]);
    return s[16:0];
  endfunction

  function automatic logic [63:0] exp_ab(int v, int s, bit feeding);
    logic [7:0] ea [4];
    logic [7:0] eb [4];
    for (int i = 0; i < 4; i++) begin
      ea[i] = '0;
      eb[i] = '0;
      for (int k = 0; k < 4; k++) begin
        if (feeding && s == i + k) begin
          ea[i] = vecs[v].a[4'(i * 4 + k)];
          eb[i] = vecs[v].b[4'(k * 4 + i)];
        end
      end
    end
    return {ea[0], ea[1], ea[2], ea[3], eb[0], eb[1], eb[2], eb[3]};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(int v);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_sel = 1'b0;
      ld_addr = 4'(k); ld_data = vecs[v].a[4'(k)];
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_sel = 1'b1;
      ld_addr = 4'(k); ld_data = vecs[v].b[4'(k)];
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic read_all(string nm, int v, bit zero);
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      #1;
      chk(nm, rd_data, zero ? 17'd0 : vecs[v].c[4'(k)]);
    end
  endtask

  task automatic run(int v, bit reload, bit restart, bit spur);
    int dones = 0;
    if (reload) load(v);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = restart && (c == 3 || c == 10 || c == 16);
      if (spur) begin
        ld_valid = (c == 4); ld_sel = 1'b0;
        ld_addr = 4'd0; ld_data = 8'd9;
      end
      if (done) dones++;
      chk("arr_clr", arr_clr, c == 1);
      chk("busy", busy, c <= 16);
      chk("done", done, c == 16);
      chk("ab_stream", {a1, a2, a3, a4, b1, b2, b3, b4},
          exp_ab(v, c - 2, c >= 2 && c <= 8));
    end
    start = 1'b0;
    ld_valid = 1'b0;
    chk("done_count", dones, 1);
    read_all("rd_data", v, 1'b0);
  endtask

  initial begin
    int dones;
    for (int k = 0; k < 16; k++) begin
      int r, c;
      r = k / 4;
      c = k % 4;
      vecs[0].a[k] = (r == c) ? 8'd1 : 8'd0;
      vecs[0].b[k] = 8'(k + 1);
      vecs[0].c[k] = 17'(k + 1);
      vecs[1].a[k] = 8'(r + 1);
      vecs[1].b[k] = 8'd2;
      vecs[1].c[k] = 17'(8 * (r + 1));
      vecs[2].a[k] = 8'd1;
      vecs[2].b[k] = 8'd1;
      vecs[2].c[k] = 17'd4;
      vecs[3].a[k] = 8'd255;
      vecs[3].b[k] = 8'd255;
      vecs[3].c[k] = 17'd129028;
      vecs[4].a[k] = 8'(16 * r + c + 1);
      vecs[4].b[k] = 8'(r + 2 * c + 3);
    end
    for (int k = 0; k < 16; k++)
      vecs[4].c[k] = mm(vecs[4], k / 4, k % 4);

    rst_n = 1'b1; ld_valid = 1'b0; ld_sel = 1'b0;
    ld_addr = '0; ld_data = '0; start = 1'b0; rd_addr = '0;
    #2 rst_n = 1'b0;
    #20;
    chk("rst_ab", {a1, a2, a3, a4, b1, b2, b3, b4}, 64'd0);
    chk("rst_ctl", {arr_clr, busy, done}, 3'd0);
    read_all("rst_rd", 0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b1, 1'b0, 1'b1);
    run(0, 1'b0, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0, 1'b0);
    run(2, 1'b1, 1'b1, 1'b0);
    run(3, 1'b1, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0, 1'b0);

    // Abort a run in FEED step 3 and confirm nothing completes.
    load(4);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ab", {a1, a2, a3, a4, b1, b2, b3, b4}, 64'd0);
    chk("mid_rst_ctl", {arr_clr, busy, done}, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_done", dones, 0);
    chk("abort_busy", busy, 1'b0);
    read_all("abort_rd", 4, 1'b1);

    run(2, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 6: number of zero-input cycles after the last skewed operand, before result capture.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port ld_valid, input, 1: writes one operand element this cycle.
REQ-005 SHALL have port ld_sel, input, 1: 0 selects matrix A, 1 selects matrix B.
REQ-006 SHALL have port ld_addr, input, 4: element index {row[3:2], col[1:0]}.
REQ-007 SHALL have port ld_data, input, 8: unsigned operand value.
REQ-008 SHALL have port start, input, 1: single-cycle request to run one 4x4 multiply.
REQ-009 SHALL have ports a1..a4, output, 8 each: skewed row streams of A, driven into the array's row inputs.
REQ-010 SHALL have ports b1..b4, output, 8 each: skewed column streams of B, driven into the array's column inputs.
REQ-011 SHALL have port arr_clr, output, 1: active-high accumulator clear for the array.
REQ-012 SHALL have ports c1..c16, input, 17 each: array results; c(4*(j-1)+i) = C[i][j], with i and j in 1..4.
REQ-013 SHALL have port rd_addr, input, 4: result index {row[3:2], col[1:0]}.
REQ-014 SHALL have port rd_data, output, 17: captured C element at rd_addr; combinational read.
REQ-015 SHALL have ports busy and done, output, 1 each: busy=1 in every non-IDLE state; done is a 1-cycle completion pulse.

Function
REQ-016 SHALL store A and B in internal 16x8 register buffers, written only when ld_valid=1 and the FSM is in IDLE; in all other states, ld_valid SHALL be ignored.
REQ-017 SHALL implement the FSM states IDLE, CLEAR, FEED, DRAIN, CAPTURE and DONE.
REQ-018 SHALL transition IDLE->CLEAR on start=1; start SHALL be ignored in every non-IDLE state.
REQ-019 SHALL remain in CLEAR for exactly 1 cycle, with arr_clr=1 and all a/b outputs at 0; arr_clr SHALL be 0 in every other state.
REQ-020 SHALL remain in FEED for exactly 7 cycles, with step s = 0..6.
REQ-021 SHALL drive, in FEED step s, ai = A[i][s-(i-1)] when 0 <= s-(i-1) <= 3, and 0 otherwise.
REQ-022 SHALL drive, in FEED step s, bj = B[s-(j-1)][j] when 0 <= s-(j-1) <= 3, and 0 otherwise.
REQ-023 SHALL register the a/b outputs, so the values for step s are visible throughout that FEED cycle.
REQ-024 SHALL remain in DRAIN for exactly DRAIN_CYCLES cycles, with all a/b outputs at 0.
REQ-025 SHALL remain in CAPTURE for 1 cycle and latch c1..c16 into a 16x17 result buffer at its closing edge.
REQ-026 SHALL, in DONE, assert done=1 for 1 cycle, then go to IDLE.
REQ-027 SHALL give a total start-to-done latency of 1+7+DRAIN_CYCLES+1 cycles, with done high in the following cycle (cycle 16 after the start cycle with the default DRAIN_CYCLES).
REQ-028 SHALL leave the result buffer unchanged from CAPTURE until the next CAPTURE; rd_data SHALL be readable in any state.
REQ-029 SHALL accept a start in the same cycle as a DONE->IDLE transition only on the next cycle, when the FSM is in IDLE.
REQ-030 SHALL leave operand buffers unmodified by a run, so a repeated start reuses the same A and B.
REQ-031 SHALL perform no arithmetic; operands are unsigned 8-bit and results are stored as received (17 bits, with any array truncation preserved).

Reset
REQ-032 SHALL, while reset=0, force asynchronously: FSM=IDLE, all a/b outputs=0, arr_clr=0, busy=0, done=0, all A/B/result buffers=0.
REQ-033 SHALL, on reset assertion mid-run, abort the run with no done pulse and leave the result buffer at 0.
REQ-034 SHALL resume operation on the first rising clk edge after reset deasserts.

Verification
REQ-035 SHALL be tested with A=identity, B[r][c]=4r+c+1, start -> done at cycle 16; rd_data at index k = k+1 for k=0..15; FEED-step-0 outputs a1=1, b1=1, all others 0.
REQ-036 SHALL be tested with A[r][c]=r+1, B all 2 -> every C[i][j] = 8*i; arr_clr is high only in the cycle after start.
REQ-037 SHALL be tested with all A=1, B=1 and start asserted again on cycles 3 and 10 -> a single run and a single done pulse; all C = 4.
REQ-038 SHALL be tested with ld_valid writing A[0][0]=9 during FEED -> ignored; a subsequent IDLE read of the result is unaffected; the next run uses the old A[0][0].
REQ-039 SHALL be tested with reset pulsed low during FEED step 3 -> all outputs 0 immediately, no done pulse; rd_data=0 for all indices.
REQ-040 SHALL be tested with a monitor checking the skew exactly: a4 nonzero only in steps 3..6, b2 = B[s-1][2] in steps 1..4 with known nonzero data.
